teclado_varredura: RTL and testbench



---
 rtl/teclado_varredura.sv | 137 +++++++++++++
 tb/tb_teclado_varredura.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/teclado_varredura.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// row reading at each column tick and reports accepted presses with a one-cycle pulse.
module teclado_varredura #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] linhas,
   output logic [3:0] colunas,
   output logic [3:0] tecla,
   output logic       tecla_valida,
   output logic       tecla_pressionada
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_t;

   state_t          state;
   logic [3:0]      linhas_m;
   logic [3:0]      linhas_s;
   logic [DW-1:0]   div;
   logic [1:0]      col;
   logic [CW-1:0]   match_cnt;
   logic [CW-1:0]   rel_cnt;
   logic [3:0]      codigo;

   logic            tick;
   logic            key_present;
   logic [1:0]      row_idx;
   logic [3:0]      code_now;
   logic [1:0]      col_next;

   // Lowest-index low row wins when several rows are pressed together.
   always_comb begin
      row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!linhas_s[i]) row_idx = 2'(i);
      end
   end

   assign tick        = (div == DW'(SCAN_DIV - 1));
   assign key_present = (linhas_s != 4'hF);
   assign code_now    = {row_idx, col};
   assign col_next    = col + 2'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         linhas_m          <= 4'hF;
         linhas_s          <= 4'hF;
         state             <= ST_SCAN;
         div               <= '0;
         col               <= 2'd0;
         colunas           <= 4'b1110;
         match_cnt         <= '0;
         rel_cnt           <= '0;
         codigo            <= 4'h0;
         tecla             <= 4'h0;
         tecla_valida      <= 1'b0;
         tecla_pressionada <= 1'b0;
      end else begin
         linhas_m     <= linhas;
         linhas_s     <= linhas_m;
         tecla_valida <= 1'b0;
         if (!enable) begin
            state             <= ST_SCAN;
            div               <= '0;
            col               <= 2'd0;
            colunas           <= 4'b1111;
            match_cnt         <= '0;
            rel_cnt           <= '0;
            tecla_pressionada <= 1'b0;
         end else begin
            div     <= tick ? '0 : div + DW'(1);
            colunas <= ~(4'b0001 << col);
            if (tick) begin
               case (state)
                  ST_SCAN: begin
                     if (key_present && DEBOUNCE == 1) begin
                        tecla             <= code_now;
                        tecla_valida      <= 1'b1;
                        tecla_pressionada <= 1'b1;
                        rel_cnt           <= '0;
                        state             <= ST_PRESSED;
                     end else if (key_present) begin
                        codigo    <= code_now;
                        match_cnt <= CW'(1);
                        state     <= ST_DEBOUNCE;
                     end else begin
                        col     <= col_next;
                        colunas <= ~(4'b0001 << col_next);
                     end
                  end
                  ST_DEBOUNCE: begin
                     if (key_present && code_now == codigo) begin
                        if (match_cnt + CW'(1) == CW'(DEBOUNCE)) begin
                           tecla             <= codigo;
                           tecla_valida      <= 1'b1;
                           tecla_pressionada <= 1'b1;
                           match_cnt         <= '0;
                           rel_cnt           <= '0;
                           state             <= ST_PRESSED;
                        end else begin
                           match_cnt <= match_cnt + CW'(1);
                        end
                     end else begin
                        match_cnt <= '0;
                        col       <= col_next;
                        colunas   <= ~(4'b0001 << col_next);
                        state     <= ST_SCAN;
                     end
                  end
                  ST_PRESSED: begin
                     // Any low row, even a different key, keeps the press alive.
                     if (key_present) begin
                        rel_cnt <= '0;
                     end else if (rel_cnt + CW'(1) == CW'(DEBOUNCE)) begin
                        rel_cnt           <= '0;
                        tecla_pressionada <= 1'b0;
                        col               <= col_next;
                        colunas           <= ~(4'b0001 << col_next);
                        state             <= ST_SCAN;
                     end else begin
                        rel_cnt <= rel_cnt + CW'(1);
                     end
                  end
                  default: state <= ST_SCAN;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_teclado_varredura.sv
// Bench for teclado_varredura: keypad matrix model, expected-code queue and an
// independent pulse monitor.
module tb_teclado_varredura;

   localparam int unsigned SD = 4;
   localparam int unsigned DB = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [3:0]  linhas;
   logic [3:0]  colunas;
   logic [3:0]  tecla;
   logic        tecla_valida;
   logic        tecla_pressionada;
   logic [15:0] keys;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [3:0]  exp_q[$];
   logic        prev_valid = 1'b0;
   logic [3:0]  exp_code;

   teclado_varredura #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .linhas            (linhas),
      .colunas           (colunas),
      .tecla             (tecla),
      .tecla_valida      (tecla_valida),
      .tecla_pressionada (tecla_pressionada)
   );

   always #5 clock = ~clock;

   // Passive keypad: a pressed key shorts its row to its column when that column is low.
   always_comb begin
      linhas = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !colunas[c]) linhas[r] = 1'b0;
   end

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] p;
      p = 4'b0001 << (c % 4);
      return ~p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every pulse must be expected, one cycle wide, and carry the queued code.
   always @(negedge clock) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (tecla_valida) begin
            check("pulse_width", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pulse: got tecla=%h, expected no pulse (t=%0t)", tecla, $time);
            end else begin
               exp_code = exp_q.pop_front();
               check("tecla_code", 32'(tecla), 32'(exp_code));
            end
            check("held_at_pulse", 32'(tecla_pressionada), 32'd1);
         end
         prev_valid = tecla_valida;
      end
   end

   task automatic wait_held(input logic want, input int bound, input string name);
      int n = 0;
      while (tecla_pressionada !== want && n < bound) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(tecla_pressionada), 32'(want));
   endtask

   task automatic wait_cols(input logic [3:0] want, input int bound);
      int n = 0;
      while (colunas !== want && n < bound) begin
         @(negedge clock);
         n++;
      end
      check("wait_cols", 32'(colunas), 32'(want));
   endtask

   task automatic press_and_check(input int c, input logic [3:0] rows, output logic [3:0] code);
      int row = 0;
      for (int r = 3; r >= 0; r--) if (rows[r]) row = r;
      code = {2'(row), 2'(c)};
      exp_q.push_back(code);
      for (int r = 0; r < 4; r++) keys[r*4+c] = rows[r];
      wait_held(1'b1, (4 + DB) * SD + 4, "press_latency");
      repeat (3) @(negedge clock);
      check("col_frozen", 32'(colunas), 32'(col_pat(c)));
      check("tecla_hold", 32'(tecla), 32'(code));
   endtask

   task automatic release_and_check(input int c);
      keys = '0;
      wait_held(1'b0, DB * SD + 4, "release_latency");
      check("col_resume", 32'(colunas), 32'(col_pat(c + 1)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] code;
      int         c;
      logic [3:0] rows;

      reset  = 1'b1;
      enable = 1'b1;
      keys   = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_colunas", 32'(colunas), 32'h0E);
      check("rst_tecla", 32'(tecla), 32'h0);
      check("rst_valida", 32'(tecla_valida), 32'h0);
      check("rst_pressionada", 32'(tecla_pressionada), 32'h0);

      // Idle scanning: each column dwells exactly SD cycles.
      for (int i = 1; i < 20; i++) begin
         @(negedge clock);
         check("idle_scan", 32'(colunas), 32'(col_pat((i / SD) % 4)));
      end

      press_and_check(1, 4'b0100, code);
      check("key_2_1", 32'(code), 32'h9);
      release_and_check(1);

      // Bounce on column 3: present for two ticks, gone before the third.
      wait_cols(4'b1110, 20);
      keys[3] = 1'b1;
      wait_cols(4'b0111, 20);
      repeat (7) @(negedge clock);
      keys = '0;
      repeat (4) @(negedge clock);
      check("bounce_frozen", 32'(colunas), 32'h7);
      @(negedge clock);
      check("bounce_advance", 32'(colunas), 32'hE);

      press_and_check(2, 4'b1010, code);
      release_and_check(2);

      for (int k = 0; k < 8; k++) begin
         c    = int'($urandom_range(0, 3));
         rows = 4'($urandom_range(1, 15));
         press_and_check(c, rows, code);
         release_and_check(c);
         repeat ($urandom_range(0, 9)) @(negedge clock);
      end

      // Disable while held, then re-enable with the key still down.
      c    = int'($urandom_range(0, 3));
      rows = 4'($urandom_range(1, 15));
      press_and_check(c, rows, code);
      enable = 1'b0;
      exp_q.push_back(code);
      @(negedge clock);
      check("dis_colunas", 32'(colunas), 32'hF);
      check("dis_pressionada", 32'(tecla_pressionada), 32'h0);
      check("dis_tecla", 32'(tecla), 32'(code));
      repeat (5) @(negedge clock);
      check("dis_colunas_hold", 32'(colunas), 32'hF);
      enable = 1'b1;
      @(negedge clock);
      check("en_colunas", 32'(colunas), 32'hE);
      wait_held(1'b1, (4 + DB) * SD + 4, "reaccept_latency");
      release_and_check(c);

      repeat (10) @(negedge clock);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
